wide_operand_bank: RTL and testbench
====================================

Name: wide_operand_bank

Overview:
Multi-slot operand store between the 32-bit bus-side write/read port and the wide-datapath core (e.g. Montgomery multiplier). Software writes NUM_SLOTS operands word-by-word. The core sees every slot in parallel and returns a wide result into a designated slot, which software reads back word-by-word. Per-slot completeness tracking replaces "last address written" detection.

Parameters:
OPERAND_W, 1024, bits per operand slot; multiple of 32
NUM_SLOTS, 3, number of operand slots (e.g. A, B, M); at least 2
RES_SLOT, 2, slot index loaded by the wide result port; less than NUM_SLOTS
ADDR_WIDTH, 10, byte-address width; at least 2+IDX_W+SLOT_W, where WORDS=OPERAND_W/32, IDX_W=clog2(WORDS), SLOT_W=clog2(NUM_SLOTS)

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
addra  in  ADDR_WIDTH  byte address; [1:0] ignored, word=[2+:IDX_W], slot=[2+IDX_W+:SLOT_W]
dina  in  32  write data
wea  in  1  word write strobe
rea  in  1  word read strobe
douta  out  32  read data
douta_valid  out  1  douta valid pulse
addr_err  out  1  pulse: access with slot >= NUM_SLOTS or word >= WORDS
slot_clear  in  NUM_SLOTS  per-slot clear pulse
slot_valid  out  NUM_SLOTS  all words of slot present
dout_slots  out  NUM_SLOTS*OPERAND_W  slot s at [s*OPERAND_W +: OPERAND_W], word 0 in the LSBs
res_data  in  OPERAND_W  wide result from core
res_valid  in  1  result offered
res_ready  out  1  result accepted when res_valid&&res_ready
res_done  out  1  pulse one cycle after result load

Behaviour:
- Reset: all slot contents 0, all word masks 0, douta=0, douta_valid=0, addr_err=0, res_done=0, slot_valid=0.
- Word write (wea, address in range): mem[slot][word]<=dina; mask[slot][word]<=1 next edge.
- Word read (rea): douta/douta_valid registered, 1-cycle latency. Out-of-range reads return 0 with douta_valid=1. wea and rea together at the same address: the read returns the old data.
- Out-of-range wea or rea: no state change; addr_err pulses 1 cycle later.
- slot_valid[s] = &mask[s] (combinational from registers), so it rises the cycle after the final missing word lands, regardless of write order. Rewriting a word keeps it valid.
- slot_clear[s]: mask[s]<=0 next edge; contents are kept. A wea to slot s in the same cycle: the clear wins for the mask, but the data write still happens.
- Result load: res_ready = !(wea && addressed slot==RES_SLOT) && !reset, combinational.
  - On res_valid&&res_ready: mem[RES_SLOT]<=res_data, mask[RES_SLOT]<=all ones; res_done=1 the next cycle.
  - A bus write to RES_SLOT stalls the core for that cycle only; no data is lost.
- Result load and slot_clear[RES_SLOT] in the same cycle: the load wins.
- Back-to-back result loads are allowed, one per cycle.
- dout_slots is a direct register view with no latency beyond the write edge.
- Reset asserted mid-sequence: everything returns to reset values at that edge. A result offered during reset is not accepted (res_ready=0).
- Word order: word 0 holds operand bits [31:0].

Decomposition:
- Shared package: WORD_W=32, helper function clog2, slot-index constants (SLOT_A=0, SLOT_B=1, SLOT_M=2), address-field offsets.
- One natural sub-module, operand_slot: one WORDS-deep register array with word mask, word write, wide load, clear and valid output. It is instantiated NUM_SLOTS times, with the wide-load port tied off except for RES_SLOT.
- The top level does address decode, the read mux, the error flag and the result handshake.

Test Plan:
Defaults (WORDS=32): slot 1 base=0x080, slot 2 base=0x100.
1. Write slot 0 words 31 down to 0 with dina=0xA000_0000+word -> slot_valid[0]=0 until the cycle after the word-0 write, then 1; dout_slots[31:0]=0xA0000000 and [1023:992]=0xA000001F.
2. Write 0xDEADBEEF at 0x084 then rea at 0x084 -> the next cycle douta=0xDEADBEEF and douta_valid=1; rea at 0x180 (slot 3) -> douta=0, addr_err=1, no state change.
3. res_valid=1 with res_data = 1024'h1234...(pattern), together with wea at 0x100 -> res_ready=0 that cycle. The next cycle the load is accepted, res_done=1 the cycle after; slot_valid[2]=1; reads of 0x100..0x17C return the pattern words.
4. Fill slot 1, pulse slot_clear[1] in the same cycle as a write of 0x5 at 0x0FC -> slot_valid[1]=0, and a read of 0x0FC returns 0x5.
5. Assert reset during a 16-word fill of slot 0 -> all outputs at reset values the next cycle; after refill of only words 16..31, slot_valid[0] stays 0.
6. Result load and slot_clear[2] in the same cycle -> slot_valid[2]=1 and res_done=1.

Source files
------------

// File: rtl/wide_operand_bank_pkg.sv
// ============================================================================
// Module      : wide_operand_bank_pkg
// Description : Shared constants and helpers for the wide operand bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wide_operand_bank_pkg;

  localparam int WORD_W   = 32;
  localparam int WORD_LSB = 2;   // byte address -> word address offset

  localparam int SLOT_A = 0;
  localparam int SLOT_B = 1;
  localparam int SLOT_M = 2;

  // Never returns 0, so single-entry fields still get a 1-bit index.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wide_operand_bank_slot.sv
// ============================================================================
// Module      : operand_slot
// Description : One operand register with per-word presence mask, word write,
//               full-width load and mask clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_slot
  import wide_operand_bank_pkg::*;
#(
  parameter int OPERAND_W = 1024,
  parameter int WORDS     = 32,
  parameter int IDX_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [WORD_W-1:0]    wr_data,
  input  logic                 load_en,
  input  logic [OPERAND_W-1:0] load_data,
  input  logic                 clear,
  output logic [OPERAND_W-1:0] data,
  output logic                 valid
);

  logic [OPERAND_W-1:0] r_data;
  logic [WORDS-1:0]     r_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_mask <= '0;
    end else if (load_en) begin
      // A full-width load overrides any clear in the same cycle.
      r_data <= load_data;
      r_mask <= '1;
    end else begin
      for (int w = 0; w < WORDS; w++) begin
        if (wr_en && wr_idx == w[IDX_W-1:0]) begin
          r_data[w*WORD_W +: WORD_W] <= wr_data;
          if (!clear) r_mask[w] <= 1'b1;
        end
      end
      if (clear) r_mask <= '0;
    end
  end

  assign data  = r_data;
  assign valid = &r_mask;

endmodule

`default_nettype wire

// File: rtl/wide_operand_bank.sv
// ============================================================================
// Module      : wide_operand_bank
// Description : Multi-slot operand store bridging a 32-bit bus port and a
//               wide-datapath core with a result load handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wide_operand_bank
  import wide_operand_bank_pkg::*;
#(
  parameter int OPERAND_W  = 1024,
  parameter int NUM_SLOTS  = 3,
  parameter int RES_SLOT   = 2,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          addra,
  input  logic [WORD_W-1:0]              dina,
  input  logic                           wea,
  input  logic                           rea,
  output logic [WORD_W-1:0]              douta,
  output logic                           douta_valid,
  output logic                           addr_err,
  input  logic [NUM_SLOTS-1:0]           slot_clear,
  output logic [NUM_SLOTS-1:0]           slot_valid,
  output logic [NUM_SLOTS*OPERAND_W-1:0] dout_slots,
  input  logic [OPERAND_W-1:0]           res_data,
  input  logic                           res_valid,
  output logic                           res_ready,
  output logic                           res_done
);

  localparam int c_WORDS    = OPERAND_W / WORD_W;
  localparam int c_IDX_W    = clog2(c_WORDS);
  localparam int c_SLOT_W   = clog2(NUM_SLOTS);
  localparam int c_SLOT_LSB = WORD_LSB + c_IDX_W;

  logic [c_IDX_W-1:0]   w_word;
  logic [c_SLOT_W-1:0]  w_slot;
  logic                 w_in_range;
  logic                 w_res_accept;
  logic [WORD_W-1:0]    w_rd_word;
  logic [OPERAND_W-1:0] w_slot_data [NUM_SLOTS];

  logic [WORD_W-1:0] r_douta;
  logic              r_douta_valid;
  logic              r_addr_err;
  logic              r_res_done;

  assign w_word     = addra[WORD_LSB +: c_IDX_W];
  assign w_slot     = addra[c_SLOT_LSB +: c_SLOT_W];
  assign w_in_range = (int'(w_slot) < NUM_SLOTS) && (int'(w_word) < c_WORDS);

  // A bus write into the result slot stalls the core for that cycle only.
  assign res_ready    = !reset && !(wea && int'(w_slot) == RES_SLOT);
  assign w_res_accept = res_valid && res_ready;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    logic                 w_wr_en;
    logic                 w_load_en;
    logic [OPERAND_W-1:0] w_load_data;

    assign w_wr_en     = wea && w_in_range && (int'(w_slot) == s);
    assign w_load_en   = (s == RES_SLOT) ? w_res_accept : 1'b0;
    assign w_load_data = (s == RES_SLOT) ? res_data : '0;

    operand_slot #(
      .OPERAND_W (OPERAND_W),
      .WORDS     (c_WORDS),
      .IDX_W     (c_IDX_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (w_wr_en),
      .wr_idx    (w_word),
      .wr_data   (dina),
      .load_en   (w_load_en),
      .load_data (w_load_data),
      .clear     (slot_clear[s]),
      .data      (w_slot_data[s]),
      .valid     (slot_valid[s])
    );

    assign dout_slots[s*OPERAND_W +: OPERAND_W] = w_slot_data[s];
  end

  // Out-of-range addresses match no entry and read back as zero.
  always_comb begin
    w_rd_word = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int w = 0; w < c_WORDS; w++) begin
        if (int'(w_slot) == s && int'(w_word) == w)
          w_rd_word = w_slot_data[s][w*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_douta       <= '0;
      r_douta_valid <= 1'b0;
      r_addr_err    <= 1'b0;
      r_res_done    <= 1'b0;
    end else begin
      r_douta_valid <= rea;
      if (rea) r_douta <= w_rd_word;
      r_addr_err    <= (wea || rea) && !w_in_range;
      r_res_done    <= w_res_accept;
    end
  end

  assign douta       = r_douta;
  assign douta_valid = r_douta_valid;
  assign addr_err    = r_addr_err;
  assign res_done    = r_res_done;

endmodule

`default_nettype wire

// File: tb/tb_wide_operand_bank.sv
// ============================================================================
// Module      : tb_wide_operand_bank
// Description : Scoreboard bench for wide_operand_bank with a word-array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wide_operand_bank;

  localparam int OW    = 1024;
  localparam int NS    = 3;
  localparam int RS    = 2;
  localparam int AW    = 10;
  localparam int WORDS = OW / 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   addra;
  logic [31:0]     dina;
  logic            wea;
  logic            rea;
  logic [31:0]     douta;
  logic            douta_valid;
  logic            addr_err;
  logic [NS-1:0]   slot_clear;
  logic [NS-1:0]   slot_valid;
  logic [NS*OW-1:0] dout_slots;
  logic [OW-1:0]   res_data;
  logic            res_valid;
  logic            res_ready;
  logic            res_done;

  wide_operand_bank #(
    .OPERAND_W (OW),
    .NUM_SLOTS (NS),
    .RES_SLOT  (RS),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addra      (addra),
    .dina       (dina),
    .wea        (wea),
    .rea        (rea),
    .douta      (douta),
    .douta_valid(douta_valid),
    .addr_err   (addr_err),
    .slot_clear (slot_clear),
    .slot_valid (slot_valid),
    .dout_slots (dout_slots),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_done   (res_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain word arrays plus a presence bit per word.
  logic [31:0] mem  [NS][WORDS];
  bit          have [NS][WORDS];
  logic [31:0] rdq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_slot(input int s);
    int bad;
    bad = -1;
    for (int w = WORDS - 1; w >= 0; w--)
      if (dout_slots[s*OW + w*32 +: 32] !== mem[s][w]) bad = w;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL dout_slots slot %0d word %0d: got %h expected %h",
               s, bad, dout_slots[s*OW + bad*32 +: 32], mem[s][bad]);
    end
  endtask

  function automatic bit model_valid(input int s);
    bit v;
    v = 1'b1;
    for (int w = 0; w < WORDS; w++) v = v & have[s][w];
    return v;
  endfunction

  function automatic logic [AW-1:0] adr(input int s, input int w);
    return AW'(s * 128 + w * 4);
  endfunction

  function automatic logic [OW-1:0] rand_wide();
    logic [OW-1:0] v;
    for (int w = 0; w < WORDS; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // One bus cycle: drive, check res_ready, advance the model at the edge, check.
  task automatic step(input logic w, input logic r, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [NS-1:0] clr,
                      input logic rv, input logic [OW-1:0] rd, input logic rst);
    int  slot, word;
    bit  inr, rdy, e_err, e_done;
    logic [AW-1:0] aa;
    aa = a;
    wea = w; rea = r; addra = a; dina = d; slot_clear = clr;
    res_valid = rv; res_data = rd; reset = rst;
    slot = int'(aa[8:7]);
    word = int'(aa[6:2]);
    inr  = slot < NS;
    rdy  = !rst && !(w && slot == RS);
    #1;
    chk("res_ready", 64'(res_ready), 64'(rdy));
    @(posedge clk);
    if (rst) begin
      for (int s = 0; s < NS; s++)
        for (int k = 0; k < WORDS; k++) begin
          mem[s][k] = '0;
          have[s][k] = 1'b0;
        end
      e_err = 0;
      e_done = 0;
    end else begin
      if (r) rdq.push_back(inr ? mem[slot][word] : 32'h0);
      e_err = (w || r) && !inr;
      if (w && inr) begin
        mem[slot][word] = d;
        have[slot][word] = 1'b1;
      end
      for (int s = 0; s < NS; s++)
        if (clr[s])
          for (int k = 0; k < WORDS; k++) have[s][k] = 1'b0;
      e_done = rv && rdy;
      if (e_done)
        for (int k = 0; k < WORDS; k++) begin
          mem[RS][k] = rd[k*32 +: 32];
          have[RS][k] = 1'b1;
        end
    end
    #1;
    chk("douta_valid", 64'(douta_valid), 64'(r && !rst));
    chk("addr_err", 64'(addr_err), 64'(e_err));
    chk("res_done", 64'(res_done), 64'(e_done));
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("slot_valid[%0d]", s), 64'(slot_valid[s]), 64'(model_valid(s)));
      chk_slot(s);
    end
  endtask

  task automatic idle();
    step(0, 0, '0, '0, '0, 0, '0, 0);
  endtask

  // Read monitor: every douta_valid pops one scoreboard entry.
  always @(negedge clk) begin
    if (douta_valid) begin
      if (rdq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL douta_unexpected: got valid with %h expected no read", douta);
      end else begin
        chk("douta", 64'(douta), 64'(rdq.pop_front()));
      end
    end
  end

  initial begin
    logic [OW-1:0] pat;
    logic [OW-1:0] pat2;
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < WORDS; k++) begin
        mem[s][k] = '0;
        have[s][k] = 1'b0;
      end
    for (int k = 0; k < WORDS; k++) pat[k*32 +: 32] = 32'h1234_0000 + 32'(k * 32'h0101);
    pat2 = rand_wide();

    step(0, 0, '0, '0, '0, 0, '0, 1);
    step(0, 0, '0, '0, '0, 1, pat2, 1);
    chk("reset_dout_slots_zero", 64'(|dout_slots), 64'd0);
    chk("reset_slot_valid", 64'(slot_valid), 64'd0);

    // Reverse-order fill of slot 0.
    for (int w = WORDS - 1; w >= 0; w--) begin
      step(1, 0, adr(0, w), 32'hA000_0000 + 32'(w), '0, 0, '0, 0);
      if (w == 1) chk("t1_not_yet_valid", 64'(slot_valid[0]), 64'd0);
    end
    chk("t1_valid", 64'(slot_valid[0]), 64'd1);
    chk("t1_lo", 64'(dout_slots[31:0]), 64'hA000_0000);
    chk("t1_hi", 64'(dout_slots[1023:992]), 64'hA000_001F);

    // Simple read, then an out-of-range read.
    step(1, 0, 10'h084, 32'hDEAD_BEEF, '0, 0, '0, 0);
    step(0, 1, 10'h084, '0, '0, 0, '0, 0);
    chk("t2_douta", 64'(douta), 64'hDEAD_BEEF);
    step(0, 1, 10'h180, '0, '0, 0, '0, 0);
    chk("t2_oor_douta", 64'(douta), 64'd0);
    chk("t2_oor_err", 64'(addr_err), 64'd1);

    // Result load stalled by a bus write to the result slot.
    step(1, 0, 10'h100, 32'h77, '0, 1, pat, 0);
    step(0, 0, '0, '0, '0, 1, pat, 0);
    chk("t3_done", 64'(res_done), 64'd1);
    chk("t3_valid", 64'(slot_valid[2]), 64'd1);
    for (int w = 0; w < WORDS; w++) step(0, 1, adr(2, w), '0, '0, 0, '0, 0);
    chk("t3_last_word", 64'(douta), 64'(32'h1234_0000 + 32'(31 * 32'h0101)));

    // Clear wins over a same-cycle write for the mask; data still lands.
    for (int w = 0; w < WORDS; w++) step(1, 0, adr(1, w), $urandom, '0, 0, '0, 0);
    chk("t4_full", 64'(slot_valid[1]), 64'd1);
    step(1, 0, 10'h0FC, 32'h5, 3'b010, 0, '0, 0);
    chk("t4_cleared", 64'(slot_valid[1]), 64'd0);
    step(0, 1, 10'h0FC, '0, '0, 0, '0, 0);
    chk("t4_data_kept", 64'(douta), 64'd5);

    // Reset mid-fill, then refill of only the upper half.
    for (int w = 0; w < 16; w++)
      step(1, 0, adr(0, w), $urandom, '0, 0, '0, (w == 8));
    for (int w = 16; w < WORDS; w++) step(1, 0, adr(0, w), $urandom, '0, 0, '0, 0);
    chk("t5_partial", 64'(slot_valid[0]), 64'd0);

    // Result load beats a same-cycle clear of the result slot.
    step(0, 0, '0, '0, 3'b100, 1, pat2, 0);
    chk("t6_valid", 64'(slot_valid[2]), 64'd1);
    chk("t6_done", 64'(res_done), 64'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) == 0, ($urandom % 3) == 0, AW'($urandom),
           $urandom, (($urandom % 10) == 0) ? NS'($urandom) : '0,
           ($urandom % 4) == 0, rand_wide(), ($urandom % 100) == 0);
    end
    idle();
    idle();
    chk("read_queue_drained", 64'(rdq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
